// File: rtl/axil_slave_regs.sv
// axil_slave_regs: AXI4-Lite responder backed by sixteen 32-bit R/W registers.
// Independent write and read FSMs, byte-strobe writes, registered responses.
// Optional macro AXIL_SLV_DECERR_EN: addresses with any bit set above bit 5
// are rejected with SLVERR (writes dropped, reads return 0). Without it,
// addresses alias modulo 64 bytes and every response is OKAY.
module axil_slave_regs #(
   parameter int ADDR_WIDTH = 32,
   parameter int NUM_REGS   = 16
) (
   input  logic                  aclk,
   input  logic                  aresetn,
   input  logic [ADDR_WIDTH-1:0] s_awaddr,
   input  logic                  s_awvalid,
   output logic                  s_awready,
   input  logic [31:0]           s_wdata,
   input  logic [3:0]            s_wstrb,
   input  logic                  s_wvalid,
   output logic                  s_wready,
   output logic [1:0]            s_bresp,
   output logic                  s_bvalid,
   input  logic                  s_bready,
   input  logic [ADDR_WIDTH-1:0] s_araddr,
   input  logic                  s_arvalid,
   output logic                  s_arready,
   output logic [31:0]           s_rdata,
   output logic [1:0]            s_rresp,
   output logic                  s_rvalid,
   input  logic                  s_rready
);

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   typedef enum logic [1:0] {W_IDLE, W_HAVE_A, W_HAVE_D, W_RESP} wstate_t;
   typedef enum logic       {R_IDLE, R_DATA} rstate_t;

   wstate_t               r_wstate, w_wnext;
   rstate_t               r_rstate, w_rnext;
   logic                  r_live;
   logic [ADDR_WIDTH-1:0] r_awaddr;
   logic [31:0]           r_wdata;
   logic [3:0]            r_wstrb;
   logic [1:0]            r_bresp;
   logic [31:0]           r_rdata;
   logic [1:0]            r_rresp;
   logic [31:0]           r_regs [NUM_REGS];

   logic                  w_aw_hs, w_w_hs, w_ar_hs;
   logic                  w_commit;
   logic [ADDR_WIDTH-1:0] w_cm_addr;
   logic [31:0]           w_cm_data;
   logic [3:0]            w_cm_strb;
   logic [3:0]            w_widx, w_ridx;
   logic                  w_wr_oor, w_rd_oor;

   // Readies are held low in reset and rise on the first edge after release,
   // even though both FSMs already sit in their idle states.
   assign s_awready = r_live && ((r_wstate == W_IDLE) || (r_wstate == W_HAVE_D));
   assign s_wready  = r_live && ((r_wstate == W_IDLE) || (r_wstate == W_HAVE_A));
   assign s_bvalid  = (r_wstate == W_RESP);
   assign s_bresp   = r_bresp;
   assign s_arready = r_live && (r_rstate == R_IDLE);
   assign s_rvalid  = (r_rstate == R_DATA);
   assign s_rdata   = r_rdata;
   assign s_rresp   = r_rresp;

   assign w_aw_hs = s_awvalid && s_awready;
   assign w_w_hs  = s_wvalid  && s_wready;
   assign w_ar_hs = s_arvalid && s_arready;

   assign w_widx = w_cm_addr[5:2];
   assign w_ridx = s_araddr[5:2];

`ifdef AXIL_SLV_DECERR_EN
   assign w_wr_oor = |(w_cm_addr >> 6);
   assign w_rd_oor = |(s_araddr >> 6);
   logic w_unused;
   assign w_unused = ^{s_araddr[1:0], w_cm_addr[1:0]};
`else
   assign w_wr_oor = 1'b0;
   assign w_rd_oor = 1'b0;
   logic w_unused;
   assign w_unused = ^{s_araddr, w_cm_addr};
`endif

   // Marks the bus live one edge after reset release.
   always_ff @(posedge aclk or posedge aresetn) begin
      if (aresetn) r_live <= 1'b0;
      else         r_live <= 1'b1;
   end

   // Write FSM state register.
   always_ff @(posedge aclk or posedge aresetn) begin
      if (aresetn) r_wstate <= W_IDLE;
      else         r_wstate <= w_wnext;
   end

   // Write next-state; selects live or latched address/data for the commit.
   always_comb begin
      w_wnext   = r_wstate;
      w_commit  = 1'b0;
      w_cm_addr = s_awaddr;
      w_cm_data = s_wdata;
      w_cm_strb = s_wstrb;
      case (r_wstate)
         W_IDLE: begin
            if (w_aw_hs && w_w_hs) begin
               w_commit = 1'b1;
               w_wnext  = W_RESP;
            end else if (w_aw_hs) begin
               w_wnext = W_HAVE_A;
            end else if (w_w_hs) begin
               w_wnext = W_HAVE_D;
            end
         end
         W_HAVE_A: begin
            w_cm_addr = r_awaddr;
            if (w_w_hs) begin
               w_commit = 1'b1;
               w_wnext  = W_RESP;
            end
         end
         W_HAVE_D: begin
            w_cm_data = r_wdata;
            w_cm_strb = r_wstrb;
            if (w_aw_hs) begin
               w_commit = 1'b1;
               w_wnext  = W_RESP;
            end
         end
         W_RESP: begin
            if (s_bready) w_wnext = W_IDLE;
         end
         default: w_wnext = W_IDLE;
      endcase
   end

   // Holding registers for whichever half of a write arrives first.
   always_ff @(posedge aclk or posedge aresetn) begin
      if (aresetn) begin
         r_awaddr <= '0;
         r_wdata  <= '0;
         r_wstrb  <= '0;
      end else begin
         if (w_aw_hs) r_awaddr <= s_awaddr;
         if (w_w_hs) begin
            r_wdata <= s_wdata;
            r_wstrb <= s_wstrb;
         end
      end
   end

   // Register bank: byte-strobed commit; out-of-range writes are dropped.
   always_ff @(posedge aclk or posedge aresetn) begin
      if (aresetn) begin
         for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
      end else if (w_commit && !w_wr_oor) begin
         for (int k = 0; k < 4; k++)
            if (w_cm_strb[k]) r_regs[w_widx][8*k +: 8] <= w_cm_data[8*k +: 8];
      end
   end

   // Write response is fixed at commit and held until accepted.
   always_ff @(posedge aclk or posedge aresetn) begin
      if (aresetn)       r_bresp <= RESP_OKAY;
      else if (w_commit) r_bresp <= w_wr_oor ? RESP_SLVERR : RESP_OKAY;
   end

   // Read FSM state register.
   always_ff @(posedge aclk or posedge aresetn) begin
      if (aresetn) r_rstate <= R_IDLE;
      else         r_rstate <= w_rnext;
   end

   // Read next-state.
   always_comb begin
      w_rnext = r_rstate;
      case (r_rstate)
         R_IDLE:  if (w_ar_hs)  w_rnext = R_DATA;
         R_DATA:  if (s_rready) w_rnext = R_IDLE;
         default: w_rnext = R_IDLE;
      endcase
   end

   // Read capture samples the bank before any same-edge commit lands.
   always_ff @(posedge aclk or posedge aresetn) begin
      if (aresetn) begin
         r_rdata <= '0;
         r_rresp <= RESP_OKAY;
      end else if (w_ar_hs) begin
         r_rdata <= w_rd_oor ? 32'h0 : r_regs[w_ridx];
         r_rresp <= w_rd_oor ? RESP_SLVERR : RESP_OKAY;
      end
   end

endmodule

// File: tb/tb_axil_slave_regs.sv
// Self-checking bench for axil_slave_regs against a word-array model.
module tb_axil_slave_regs;
   logic        aclk = 1'b0;
   logic        aresetn = 1'b1;
   logic [31:0] s_awaddr = '0, s_wdata = '0, s_araddr = '0;
   logic [3:0]  s_wstrb = '0;
   logic        s_awvalid = 0, s_wvalid = 0, s_bready = 0, s_arvalid = 0, s_rready = 0;
   logic        s_awready, s_wready, s_bvalid, s_arready, s_rvalid;
   logic [1:0]  s_bresp, s_rresp;
   logic [31:0] s_rdata;

   int checks = 0;
   int failures = 0;
   logic [31:0] mdl [16];

   axil_slave_regs #(.ADDR_WIDTH(32), .NUM_REGS(16)) dut (
      .aclk(aclk), .aresetn(aresetn),
      .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
      .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
      .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
      .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
      .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready)
   );

   always #5 aclk = ~aclk;

   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                         input logic [3:0] s);
      logic [31:0] r;
      r = old;
      for (int k = 0; k < 4; k++) if (s[k]) r[8*k +: 8] = d[8*k +: 8];
      return r;
   endfunction

   function automatic bit in_range(input logic [31:0] a);
`ifdef AXIL_SLV_DECERR_EN
      return (a >> 6) == 0;
`else
      return 1'b1;
`endif
   endfunction

   task automatic model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
      if (in_range(a)) mdl[(a >> 2) & 32'hF] = merge(mdl[(a >> 2) & 32'hF], d, s);
   endtask

   // Full write; b_now reports whether bvalid was up right after the final handshake edge.
   task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                            output logic [1:0] resp, output logic b_now);
      bit aw_done = 0, w_done = 0, aw_hs, w_hs;
      int n = 0;
      s_awaddr = a; s_wdata = d; s_wstrb = s; s_awvalid = 1; s_wvalid = 1;
      while (!(aw_done && w_done) && n < 50) begin
         @(negedge aclk);
         aw_hs = s_awvalid && s_awready;
         w_hs  = s_wvalid && s_wready;
         @(posedge aclk); #1;
         if (aw_hs) begin s_awvalid = 0; aw_done = 1; end
         if (w_hs)  begin s_wvalid = 0;  w_done = 1;  end
         n++;
      end
      b_now = s_bvalid;
      n = 0;
      while (!s_bvalid && n < 50) begin @(posedge aclk); #1; n++; end
      checks++;
      if (!s_bvalid) begin
         failures++;
         $display("FAIL wr_timeout addr=%h bvalid=%b required=1", a, s_bvalid);
         s_awvalid = 0; s_wvalid = 0;
      end
      resp = s_bresp;
      s_bready = 1;
      @(posedge aclk); #1;
      s_bready = 0;
   endtask

   task automatic axi_read(input logic [31:0] a, output logic [31:0] d, output logic [1:0] resp,
                           output logic r_now);
      bit hs = 0;
      int n = 0;
      s_araddr = a; s_arvalid = 1;
      while (!hs && n < 50) begin
         @(negedge aclk);
         hs = s_arready;
         @(posedge aclk); #1;
         n++;
      end
      s_arvalid = 0;
      r_now = s_rvalid;
      n = 0;
      while (!s_rvalid && n < 50) begin @(posedge aclk); #1; n++; end
      checks++;
      if (!s_rvalid) begin
         failures++;
         $display("FAIL rd_timeout addr=%h rvalid=%b required=1", a, s_rvalid);
      end
      @(negedge aclk);
      d = s_rdata; resp = s_rresp;
      s_rready = 1;
      @(posedge aclk); #1;
      s_rready = 0;
   endtask

   task automatic test_reset();
      for (int i = 0; i < 16; i++) mdl[i] = '0;
      aresetn = 1;
      repeat (2) @(posedge aclk);
      @(negedge aclk);
      checks++;
      if ({s_awready, s_wready, s_arready, s_bvalid, s_rvalid, s_bresp, s_rresp, s_rdata} !== '0) begin
         failures++;
         $display("FAIL reset_outputs got=%b %b %b %b %b %b %b %h required all zero",
                  s_awready, s_wready, s_arready, s_bvalid, s_rvalid, s_bresp, s_rresp, s_rdata);
      end
      aresetn = 0;
      #1;
      checks++;
      if ({s_awready, s_wready, s_arready} !== 3'b000) begin
         failures++;
         $display("FAIL ready_before_edge got=%b required=000", {s_awready, s_wready, s_arready});
      end
      @(posedge aclk); #1;
      checks++;
      if ({s_awready, s_wready, s_arready} !== 3'b111) begin
         failures++;
         $display("FAIL ready_after_edge got=%b required=111", {s_awready, s_wready, s_arready});
      end
   endtask

   task automatic test_basic();
      logic [1:0] resp; logic now; logic [31:0] d;
      axi_write(32'h00, 32'hABCD1234, 4'hF, resp, now);
      model_write(32'h00, 32'hABCD1234, 4'hF);
      checks++;
      if (resp !== 2'b00 || now !== 1'b1) begin
         failures++;
         $display("FAIL basic_write resp=%b bvalid_at_edge=%b required 00/1", resp, now);
      end
      axi_read(32'h00, d, resp, now);
      checks++;
      if (d !== 32'hABCD1234 || resp !== 2'b00 || now !== 1'b1) begin
         failures++;
         $display("FAIL basic_read data=%h resp=%b rvalid_at_edge=%b required ABCD1234/00/1", d, resp, now);
      end
   endtask

   task automatic test_strobes();
      logic [31:0] wd [4]  = '{32'h12345678, 32'h000000AA, 32'h00BB0000, 32'hDD00CC00};
      logic [3:0]  ws [4]  = '{4'b1111, 4'b0001, 4'b0100, 4'b1010};
      logic [31:0] exp [4] = '{32'h12345678, 32'h123456AA, 32'h12BB56AA, 32'hDDBBCCAA};
      logic [1:0] resp; logic now; logic [31:0] d;
      for (int i = 0; i < 4; i++) begin
         axi_write(32'h20, wd[i], ws[i], resp, now);
         model_write(32'h20, wd[i], ws[i]);
         axi_read(32'h20, d, resp, now);
         checks++;
         if (d !== exp[i] || d !== mdl[8]) begin
            failures++;
            $display("FAIL strobe_%0d got=%h required=%h", i, d, exp[i]);
         end
      end
   endtask

   task automatic test_split();
      logic [1:0] resp; logic now; logic [31:0] d;
      logic [1:0] b0;
      // Address first, data three cycles later.
      s_awaddr = 32'h08; s_awvalid = 1;
      @(posedge aclk); #1; s_awvalid = 0;
      repeat (3) begin
         @(negedge aclk);
         checks++;
         if ({s_awready, s_wready, s_bvalid} !== 3'b010) begin
            failures++;
            $display("FAIL have_a_state got=%b required=010", {s_awready, s_wready, s_bvalid});
         end
      end
      s_wdata = 32'h11112222; s_wstrb = 4'hF; s_wvalid = 1;
      @(posedge aclk); #1; s_wvalid = 0;
      model_write(32'h08, 32'h11112222, 4'hF);
      b0 = s_bresp;
      repeat (4) begin
         @(negedge aclk);
         checks++;
         if ({s_bvalid, s_awready, s_wready} !== 3'b100 || s_bresp !== 2'b00 || s_bresp !== b0) begin
            failures++;
            $display("FAIL b_hold got=%b bresp=%b required=100 bresp=00",
                     {s_bvalid, s_awready, s_wready}, s_bresp);
         end
      end
      s_bready = 1; @(posedge aclk); #1; s_bready = 0;
      // Data first, address three cycles later, partial strobe.
      s_wdata = 32'h33334444; s_wstrb = 4'b0011; s_wvalid = 1;
      @(posedge aclk); #1; s_wvalid = 0;
      repeat (3) begin
         @(negedge aclk);
         checks++;
         if ({s_awready, s_wready, s_bvalid} !== 3'b100) begin
            failures++;
            $display("FAIL have_d_state got=%b required=100", {s_awready, s_wready, s_bvalid});
         end
      end
      s_awaddr = 32'h08; s_awvalid = 1;
      @(posedge aclk); #1; s_awvalid = 0;
      model_write(32'h08, 32'h33334444, 4'b0011);
      repeat (4) begin
         @(negedge aclk);
         checks++;
         if ({s_bvalid, s_awready, s_wready} !== 3'b100 || s_bresp !== 2'b00) begin
            failures++;
            $display("FAIL b_hold2 got=%b bresp=%b required=100 bresp=00",
                     {s_bvalid, s_awready, s_wready}, s_bresp);
         end
      end
      s_bready = 1; @(posedge aclk); #1; s_bready = 0;
      axi_read(32'h08, d, resp, now);
      checks++;
      if (d !== mdl[2] || d !== 32'h11114444) begin
         failures++;
         $display("FAIL split_readback got=%h required=11114444", d);
      end
   endtask

   task automatic test_same_cycle();
      logic [1:0] resp; logic now; logic [31:0] d;
      axi_write(32'h24, 32'hAAAAAAAA, 4'hF, resp, now);
      model_write(32'h24, 32'hAAAAAAAA, 4'hF);
      s_awaddr = 32'h24; s_wdata = 32'hCCCCCCCC; s_wstrb = 4'hF; s_araddr = 32'h24;
      s_awvalid = 1; s_wvalid = 1; s_arvalid = 1;
      @(negedge aclk);
      checks++;
      if ({s_awready, s_wready, s_arready} !== 3'b111) begin
         failures++;
         $display("FAIL same_ready got=%b required=111", {s_awready, s_wready, s_arready});
      end
      @(posedge aclk); #1;
      s_awvalid = 0; s_wvalid = 0; s_arvalid = 0;
      @(negedge aclk);
      checks++;
      if (s_rvalid !== 1'b1 || s_bvalid !== 1'b1 || s_rdata !== 32'hAAAAAAAA) begin
         failures++;
         $display("FAIL same_edge rvalid=%b bvalid=%b rdata=%h required 1/1/AAAAAAAA",
                  s_rvalid, s_bvalid, s_rdata);
      end
      s_bready = 1; s_rready = 1;
      @(posedge aclk); #1;
      s_bready = 0; s_rready = 0;
      model_write(32'h24, 32'hCCCCCCCC, 4'hF);
      axi_read(32'h24, d, resp, now);
      checks++;
      if (d !== 32'hCCCCCCCC || d !== mdl[9]) begin
         failures++;
         $display("FAIL same_after got=%h required=CCCCCCCC", d);
      end
   endtask

   task automatic test_reset_mid();
      logic [1:0] resp; logic now; logic [31:0] d;
      s_awaddr = 32'h10; s_wdata = 32'hDEADBEEF; s_wstrb = 4'hF; s_awvalid = 1;
      @(posedge aclk); #1; s_awvalid = 0;
      aresetn = 1;
      #1;
      checks++;
      if ({s_awready, s_wready, s_arready, s_bvalid, s_rvalid} !== 5'b0) begin
         failures++;
         $display("FAIL async_reset got=%b required=00000",
                  {s_awready, s_wready, s_arready, s_bvalid, s_rvalid});
      end
      repeat (3) @(posedge aclk);
      #1; aresetn = 0;
      for (int i = 0; i < 16; i++) mdl[i] = '0;
      repeat (3) @(posedge aclk);
      @(negedge aclk);
      checks++;
      if (s_bvalid !== 1'b0 || s_rvalid !== 1'b0 || {s_awready, s_wready} !== 2'b11) begin
         failures++;
         $display("FAIL post_reset bvalid=%b rvalid=%b readies=%b required 0/0/11",
                  s_bvalid, s_rvalid, {s_awready, s_wready});
      end
      axi_read(32'h00, d, resp, now);
      checks++;
      if (d !== mdl[0]) begin failures++; $display("FAIL rst_read0 got=%h required=%h", d, mdl[0]); end
      axi_read(32'h10, d, resp, now);
      checks++;
      if (d !== mdl[4]) begin failures++; $display("FAIL rst_read10 got=%h required=%h", d, mdl[4]); end
   endtask

   task automatic test_addr_range();
      logic [1:0] resp; logic now; logic [31:0] d;
      axi_write(32'h40, 32'h55555555, 4'hF, resp, now);
      model_write(32'h40, 32'h55555555, 4'hF);
`ifdef AXIL_SLV_DECERR_EN
      checks++;
      if (resp !== 2'b10) begin failures++; $display("FAIL oor_bresp got=%b required=10", resp); end
      axi_read(32'h40, d, resp, now);
      checks++;
      if (d !== 32'h0 || resp !== 2'b10) begin
         failures++;
         $display("FAIL oor_read got=%h/%b required=00000000/10", d, resp);
      end
`else
      checks++;
      if (resp !== 2'b00) begin failures++; $display("FAIL alias_bresp got=%b required=00", resp); end
`endif
      axi_read(32'h00, d, resp, now);
      checks++;
      if (d !== mdl[0] || resp !== 2'b00) begin
         failures++;
         $display("FAIL range_read0 got=%h/%b required=%h/00", d, resp, mdl[0]);
      end
   endtask

   task automatic test_back_to_back();
      int wh = 0, rh = 0;
      s_awaddr = 32'h30; s_wdata = 32'h0BADF00D; s_wstrb = 4'hF; s_araddr = 32'h30;
      s_bready = 1; s_rready = 1;
      s_awvalid = 1; s_wvalid = 1;
      repeat (8) begin
         @(negedge aclk);
         if (s_awready && s_wready) wh++;
         @(posedge aclk);
      end
      #1; s_awvalid = 0; s_wvalid = 0;
      model_write(32'h30, 32'h0BADF00D, 4'hF);
      @(posedge aclk); #1;
      s_arvalid = 1;
      repeat (8) begin
         @(negedge aclk);
         if (s_arready) rh++;
         if (s_rvalid) begin
            checks++;
            if (s_rdata !== mdl[12]) begin
               failures++;
               $display("FAIL b2b_rdata got=%h required=%h", s_rdata, mdl[12]);
            end
         end
         @(posedge aclk);
      end
      #1; s_arvalid = 0;
      @(posedge aclk); #1;
      s_bready = 0; s_rready = 0;
      checks++;
      if (wh !== 4 || rh !== 4) begin
         failures++;
         $display("FAIL b2b_rate writes=%0d reads=%0d required 4/4", wh, rh);
      end
   endtask

   task automatic test_random();
      logic [1:0] resp; logic now; logic [31:0] d, a, wd;
      logic [3:0] st;
      for (int i = 0; i < 60; i++) begin
         a = {26'h0, 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3))};
         if ($urandom_range(0, 1) == 1) begin
            wd = $urandom; st = 4'($urandom_range(0, 15));
            axi_write(a, wd, st, resp, now);
            model_write(a, wd, st);
            checks++;
            if (resp !== 2'b00 || now !== 1'b1) begin
               failures++;
               $display("FAIL rand_write addr=%h resp=%b bvalid_at_edge=%b required 00/1", a, resp, now);
            end
         end else begin
            axi_read(a, d, resp, now);
            checks++;
            if (d !== mdl[a[5:2]] || resp !== 2'b00 || now !== 1'b1) begin
               failures++;
               $display("FAIL rand_read addr=%h got=%h/%b required=%h/00", a, d, resp, mdl[a[5:2]]);
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_strobes();
      test_split();
      test_same_cycle();
      test_reset_mid();
      test_addr_range();
      test_back_to_back();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/axil_slave_regs.md
# axil_slave_regs

AXI4-Lite slave (responder) exposing a bank of sixteen 32-bit read/write registers. It terminates the AXI-Lite bus driven by the team's AXI-Lite master, the one with the `wr_req`/`rd_req` user interface. It is the memory the master's tests write, read back and check. Independent write and read FSMs allow concurrent transactions, with byte-strobe writes and registered responses.

## Interface
- `ADDR_WIDTH`, 32, AXI address width.
- `NUM_REGS`, 16, register count; fixed at 16, with index = `addr[5:2]`.
- `aclk`  in  1  clock; all logic samples on the rising edge.
- `aresetn`  in  1  reset, asynchronous, active-high.
- `s_awaddr`  in  ADDR_WIDTH  write address.
- `s_awvalid` / `s_awready`  in / out  1  write address handshake.
- `s_wdata`  in  32  write data.
- `s_wstrb`  in  4  byte strobes; bit k enables byte lane [8k+7:8k].
- `s_wvalid` / `s_wready`  in / out  1  write data handshake.
- `s_bresp`  out  2  write response.
- `s_bvalid` / `s_bready`  out / in  1  write response handshake.
- `s_araddr`  in  ADDR_WIDTH  read address.
- `s_arvalid` / `s_arready`  in / out  1  read address handshake.
- `s_rdata`  out  32  read data.
- `s_rresp`  out  2  read response.
- `s_rvalid` / `s_rready`  out / in  1  read data handshake.

## Operation
- Register index is `addr[5:2]`. `addr[1:0]` is ignored; unaligned addresses act on the containing word.
- Write FSM states:
  - W_IDLE: awready=1, wready=1.
  - W_HAVE_A: address latched, awready=0, wready=1.
  - W_HAVE_D: data and strobes latched, awready=1, wready=0.
  - W_RESP: bvalid=1, both readies 0.
- Write transitions:
  - AW and W handshake on the same edge in W_IDLE: commit, go to W_RESP.
  - AW only: go to W_HAVE_A. W only: go to W_HAVE_D.
  - Completing handshake in W_HAVE_A or W_HAVE_D: commit, go to W_RESP.
  - W_RESP to W_IDLE on bvalid && bready.
- Commit updates only the strobed bytes. `wstrb`=0000 commits nothing but still returns a response.
- Read FSM states:
  - R_IDLE: arready=1.
  - R_DATA: rvalid=1, arready=0.
- Read transition: arvalid && arready captures the register into `s_rdata` and enters R_DATA. R_DATA returns to R_IDLE on rvalid && rready.
- `rdata`, `rresp`, `bresp` are held stable while their valid is high, regardless of ready.
- Same-edge write commit and read capture to the same index: the read returns the pre-write value. The write is visible to any later read.
- Read and write FSMs never block each other.

## Timing
- Reset asserted (`aresetn`=1):
  - All registers 0.
  - Both FSMs idle.
  - All outputs 0, including readies, `bresp`, `rresp`, `rdata`.
- Readies rise on the first `aclk` edge after reset deasserts.
- Write latency: final AW/W handshake at edge N, register updated at edge N, bvalid high from edge N.
- Minimum write throughput: 1 transaction per 2 cycles, with bready tied high.
- Read latency: AR handshake at edge N, rvalid and rdata valid from edge N.
- Minimum read throughput: 1 per 2 cycles, with rready tied high.
- Reset mid-transaction: latched address/data are discarded and no B/R response is issued. Outputs go to reset values immediately (asynchronous).

## Configuration
- `AXIL_SLV_DECERR_EN` defined:
  - Any address with a nonzero bit in [ADDR_WIDTH-1:6] is out of range.
  - Out-of-range writes commit nothing and return bresp=2'b10 (SLVERR).
  - Out-of-range reads return rdata=0 and rresp=2'b10.
- Undefined: upper address bits are ignored, addresses alias modulo 64 bytes, and every response is 2'b00 (OKAY).

## Test plan
- Reset, then write 0x00 = 0xABCD1234 with strb 1111, then read 0x00 -> rdata 0xABCD1234, rresp 00; bvalid exactly 1 cycle after the AW+W edge.
- Partial strobes on 0x20:
  - write 0x12345678 strb 1111 -> reads 0x12345678;
  - write 0x000000AA strb 0001 -> reads 0x123456AA;
  - write 0x00BB0000 strb 0100 -> reads 0x12BB56AA;
  - write 0xDD00CC00 strb 1010 -> reads 0xDDBBCCAA.
- AW presented 3 cycles before W, then W presented 3 cycles before AW, with bready held low 4 cycles: each write commits exactly once, and bresp stays stable and awready/wready stay low until bready.
- Preload 0x24 = 0xAAAAAAAA, then same-cycle write 0x24 = 0xCCCCCCCC and read 0x24 -> read returns 0xAAAAAAAA; a following read returns 0xCCCCCCCC.
- Write 0x10 = 0xDEADBEEF with AW accepted and W withheld, assert reset 3 cycles, release -> no bvalid; reads of 0x00 and 0x10 return 0.
- Write to 0x40 = 0x55555555 ->
  - with `AXIL_SLV_DECERR_EN`: bresp 10, reading 0x40 gives 0 with rresp 10, and 0x00 is unchanged.
  - without it: 0x00 reads 0x55555555, resp 00.
